// File: rtl/debounce_bank.sv
// Bank of independent hysteretic debouncers with optional input synchronizers,
// edge pulses and a per-channel press-toggle output mode.
module debounce_bank #(
  parameter int unsigned NUM_CH  = 8,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned ON_THR  = 12,
  parameter int unsigned OFF_THR = 3,
  parameter int unsigned SYNC_EN = 1
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              enable,
  input  logic [NUM_CH-1:0] in,
  input  logic [NUM_CH-1:0] mode_toggle,
  output logic [NUM_CH-1:0] out_filt,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic              any_change
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ON_LVL  = CNT_W'(ON_THR);
  localparam logic [CNT_W-1:0] OFF_LVL = CNT_W'(OFF_THR);

  typedef enum logic {LOW = 1'b0, HIGH = 1'b1} lvl_t;

  logic [NUM_CH-1:0] filt_in;
  logic [CNT_W-1:0]  cnt     [NUM_CH];
  logic [CNT_W-1:0]  cnt_nxt [NUM_CH];
  lvl_t              lvl     [NUM_CH];
  logic [NUM_CH-1:0] tgl;
  logic [NUM_CH-1:0] rise_nxt;
  logic [NUM_CH-1:0] fall_nxt;

  // Synchronizers keep running while enable is low; only reset clears them.
  generate
    if (SYNC_EN != 0) begin : g_sync
      logic [NUM_CH-1:0] sync1;
      logic [NUM_CH-1:0] sync2;
      always_ff @(posedge clk) begin
        if (resetN) begin
          sync1 <= '0;
          sync2 <= '0;
        end else begin
          sync1 <= in;
          sync2 <= sync1;
        end
      end
      assign filt_in = sync2;
    end else begin : g_nosync
      assign filt_in = in;
    end
  endgenerate

  // Saturating counter update and threshold crossing detection on the new count.
  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      cnt_nxt[i]  = cnt[i];
      rise_nxt[i] = 1'b0;
      fall_nxt[i] = 1'b0;
      if (filt_in[i]) begin
        if (cnt[i] != CNT_MAX) cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end else begin
        if (cnt[i] != '0) cnt_nxt[i] = cnt[i] - CNT_W'(1);
      end
      if (lvl[i] == LOW && cnt_nxt[i] >= ON_LVL) rise_nxt[i] = 1'b1;
      if (lvl[i] == HIGH && cnt_nxt[i] <= OFF_LVL) fall_nxt[i] = 1'b1;
    end
  end

  // Level FSMs, toggle registers and pulse registers; frozen while disabled.
  always_ff @(posedge clk) begin
    if (resetN) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        cnt[i] <= '0;
        lvl[i] <= LOW;
      end
      tgl        <= '0;
      rise       <= '0;
      fall       <= '0;
      any_change <= 1'b0;
    end else if (enable) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        cnt[i] <= cnt_nxt[i];
        case (lvl[i])
          LOW:     if (rise_nxt[i]) lvl[i] <= HIGH;
          HIGH:    if (fall_nxt[i]) lvl[i] <= LOW;
          default: lvl[i] <= LOW;
        endcase
      end
      tgl        <= tgl ^ rise_nxt;
      rise       <= rise_nxt;
      fall       <= fall_nxt;
      any_change <= |{rise_nxt, fall_nxt};
    end else begin
      rise       <= '0;
      fall       <= '0;
      any_change <= 1'b0;
    end
  end

  // Mode select is combinational so switching modes never disturbs state.
  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      out_filt[i] = mode_toggle[i] ? tgl[i] : (lvl[i] == HIGH);
    end
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Randomized and directed scoreboard bench for debounce_bank at default parameters.
module tb_debounce_bank;

  localparam int N      = 8;
  localparam int CMAX   = 15;
  localparam int ON_T   = 12;
  localparam int OFF_T  = 3;

  typedef struct packed {
    logic [N-1:0] of;
    logic [N-1:0] rs;
    logic [N-1:0] fl;
    logic         ac;
  } exp_t;

  logic         clk = 1'b0;
  logic         resetN;
  logic         enable;
  logic [N-1:0] din;
  logic [N-1:0] mode_toggle;
  logic [N-1:0] out_filt;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic         any_change;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  exp_t exp_q[$];

  // Reference model: input delay line, integer counts, level/toggle/pulse bits.
  logic [N-1:0] dly_q[$];
  int           m_cnt[N];
  bit           m_hi[N];
  bit           m_tg[N];
  bit           m_rs[N];
  bit           m_fl[N];
  bit           model_ok = 1'b0;

  debounce_bank dut (
    .clk         (clk),
    .resetN      (resetN),
    .enable      (enable),
    .in          (din),
    .mode_toggle (mode_toggle),
    .out_filt    (out_filt),
    .rise        (rise),
    .fall        (fall),
    .any_change  (any_change)
  );

  always #5 clk = ~clk;

  task automatic model_edge(input logic rst, input logic en, input logic [N-1:0] iv);
    logic [N-1:0] feed;
    if (rst) begin
      dly_q.delete();
      dly_q.push_back('0);
      dly_q.push_back('0);
      for (int i = 0; i < N; i++) begin
        m_cnt[i] = 0; m_hi[i] = 0; m_tg[i] = 0; m_rs[i] = 0; m_fl[i] = 0;
      end
      model_ok = 1'b1;
      return;
    end
    feed = dly_q.pop_front();
    dly_q.push_back(iv);
    for (int i = 0; i < N; i++) begin
      m_rs[i] = 0;
      m_fl[i] = 0;
      if (en) begin
        m_cnt[i] = feed[i] ? ((m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX)
                           : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
        if (!m_hi[i] && m_cnt[i] >= ON_T) begin
          m_hi[i] = 1; m_rs[i] = 1; m_tg[i] = ~m_tg[i];
        end else if (m_hi[i] && m_cnt[i] <= OFF_T) begin
          m_hi[i] = 0; m_fl[i] = 1;
        end
      end
    end
  endtask

  task automatic push_expect(input logic [N-1:0] md);
    exp_t e;
    e.ac = 1'b0;
    for (int i = 0; i < N; i++) begin
      e.of[i] = md[i] ? m_tg[i] : m_hi[i];
      e.rs[i] = m_rs[i];
      e.fl[i] = m_fl[i];
      e.ac    = e.ac | m_rs[i] | m_fl[i];
    end
    exp_q.push_back(e);
  endtask

  // Apply inputs for one cycle; expectation for the current cycle uses the new mode.
  task automatic step(input logic rst, input logic en, input logic [N-1:0] iv,
                      input logic [N-1:0] md);
    resetN      = rst;
    enable      = en;
    din         = iv;
    mode_toggle = md;
    if (model_ok) push_expect(md);
    @(posedge clk);
    #1;
    model_edge(rst, en, iv);
    cyc++;
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total += 4;
        if (out_filt !== e.of) begin
          bad++; $display("FAIL out_filt cyc=%0d got=%h exp=%h", cyc, out_filt, e.of);
        end
        if (rise !== e.rs) begin
          bad++; $display("FAIL rise cyc=%0d got=%h exp=%h", cyc, rise, e.rs);
        end
        if (fall !== e.fl) begin
          bad++; $display("FAIL fall cyc=%0d got=%h exp=%h", cyc, fall, e.fl);
        end
        if (any_change !== e.ac) begin
          bad++; $display("FAIL any_change cyc=%0d got=%b exp=%b", cyc, any_change, e.ac);
        end
      end
    end
  end

  initial begin
    int           lat;
    int           npulse;
    int           nac;
    logic [N-1:0] cur;
    logic [N-1:0] md;
    logic         en;
    logic         rst;

    resetN = 1'b1; enable = 1'b1; din = '0; mode_toggle = '0;

    // Reset held 3 cycles with all inputs high, then first rise latency.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, '1, '0);
    lat = -1; npulse = 0;
    for (int k = 1; k <= 24; k++) begin
      step(1'b0, 1'b1, '1, '0);
      if (rise[0] === 1'b1) begin
        npulse++;
        if (lat < 0) lat = k;
      end
    end
    total++;
    if (lat != 14) begin bad++; $display("FAIL rise0_latency got=%0d exp=14", lat); end
    total++;
    if (npulse != 1) begin bad++; $display("FAIL rise0_width got=%0d exp=1", npulse); end

    // Short press of 11 cycles on channel 1 never qualifies.
    step(1'b1, 1'b1, '0, '0);
    for (int k = 0; k < 11; k++) step(1'b0, 1'b1, N'(8'h02), '0);
    for (int k = 0; k < 16; k++) step(1'b0, 1'b1, '0, '0);

    // Saturate, release, then a burst back to 1 in the hysteresis band.
    for (int k = 0; k < 22; k++) step(1'b0, 1'b1, '1, '0);
    for (int k = 0; k < 7; k++)  step(1'b0, 1'b1, '0, '0);
    for (int k = 0; k < 3; k++)  step(1'b0, 1'b1, '1, '0);
    for (int k = 0; k < 20; k++) step(1'b0, 1'b1, '0, '0);

    // Toggle mode on channel 2: three presses, then back to level mode mid-press.
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 16; k++) step(1'b0, 1'b1, N'(8'h04), N'(8'h04));
      for (int k = 0; k < 16; k++) step(1'b0, 1'b1, '0, N'(8'h04));
    end
    for (int k = 0; k < 16; k++) step(1'b0, 1'b1, N'(8'h04), N'(8'h04));
    for (int k = 0; k < 4; k++)  step(1'b0, 1'b1, N'(8'h04), '0);
    for (int k = 0; k < 16; k++) step(1'b0, 1'b1, '0, '0);

    // Enable low for 20 cycles during a stable press.
    for (int k = 0; k < 8; k++)  step(1'b0, 1'b1, '1, '0);
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0, '1, '0);
    for (int k = 0; k < 20; k++) step(1'b0, 1'b1, '1, '0);
    for (int k = 0; k < 18; k++) step(1'b0, 1'b1, '0, '0);

    // Reset coinciding with a rise pulse.
    step(1'b1, 1'b1, '0, '0);
    for (int k = 0; k < 14; k++) step(1'b0, 1'b1, N'(8'h01), '0);
    step(1'b1, 1'b1, N'(8'h01), '0);
    step(1'b0, 1'b1, '0, '0);

    // Simultaneous rise on channel 0 and fall on channel 3.
    for (int k = 0; k < 20; k++) step(1'b0, 1'b1, N'(8'h08), '0);
    nac = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b1, N'(8'h01), '0);
      if (any_change === 1'b1) nac++;
    end
    total++;
    if (nac != 1) begin bad++; $display("FAIL coincident_any_change got=%0d exp=1", nac); end

    // Randomized slowly-changing inputs with occasional disable/reset/mode changes.
    cur = '0; md = '0;
    for (int k = 0; k < 1500; k++) begin
      if (k % 60 == 0) md = N'($urandom);
      cur ^= N'($urandom & $urandom & $urandom & $urandom & $urandom);
      en  = ($urandom_range(0, 19) != 0);
      rst = ($urandom_range(0, 399) == 0);
      step(rst, en, cur, md);
    end
    step(1'b0, 1'b1, '0, '0);

    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 8: number of independent input channels (1..32).
REQ-002 SHALL have parameter CNT_W, default 4: per-channel counter width; CNT_MAX = 2^CNT_W-1.
REQ-003 SHALL have parameter ON_THR, default 12: counter value at or above which a channel goes high.
REQ-004 SHALL have parameter OFF_THR, default 3: counter value at or below which a channel goes low; legal only when OFF_THR < ON_THR <= CNT_MAX.
REQ-005 SHALL have parameter SYNC_EN, default 1: 1 inserts a 2-flop synchronizer per channel; 0 bypasses it.
REQ-006 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-007 SHALL have port resetN, input, 1 bit: reset, synchronous and active-high (asserted when 1).
REQ-008 SHALL have port enable, input, 1 bit: 1 = filtering runs; 0 = all state frozen.
REQ-009 SHALL have port in, input, NUM_CH bits: raw, possibly asynchronous, bouncing inputs.
REQ-010 SHALL have port mode_toggle, input, NUM_CH bits: per channel, 0 = level mode, 1 = toggle mode.
REQ-011 SHALL have port out_filt, output, NUM_CH bits: debounced level, or toggle state in toggle mode.
REQ-012 SHALL have port rise, output, NUM_CH bits: one-cycle pulse on each debounced 0->1 transition.
REQ-013 SHALL have port fall, output, NUM_CH bits: one-cycle pulse on each debounced 1->0 transition.
REQ-014 SHALL have port any_change, output, 1 bit: OR of all rise and fall bits in the same cycle.

Function
REQ-015 SHALL process each channel independently, with no cross-channel interaction other than any_change.
REQ-016 SHALL, when SYNC_EN=1, feed the counter from the second synchronizer stage, adding exactly 2 cycles of latency; when SYNC_EN=0 it SHALL feed in[i] directly.
REQ-017 SHALL, on each edge with enable=1, increment the counter (saturating at CNT_MAX) when the filter input is 1, and decrement it (saturating at 0) when the input is 0.
REQ-018 SHALL hold a per-channel level-state FSM with states LOW and HIGH, evaluated on the post-update counter value of the same edge.
REQ-019 SHALL move LOW->HIGH when the new counter >= ON_THR, and HIGH->LOW when the new counter <= OFF_THR; it SHALL hold the state for counter values strictly between the two thresholds (hysteresis).
REQ-020 SHALL register rise[i]/fall[i] as 1 exactly in the cycle following the edge on which the FSM changed state, and 0 otherwise; the pulses SHALL be coincident with the new level.
REQ-021 SHALL keep a per-channel toggle register that inverts on every rise[i] event, regardless of mode_toggle.
REQ-022 SHALL drive out_filt[i] as the level state when mode_toggle[i]=0, and as the toggle register when mode_toggle[i]=1; a mode change SHALL take effect combinationally, with no state modified.
REQ-023 SHALL, while enable=0, freeze counters, FSMs and toggle registers, force rise, fall and any_change to 0, and keep synchronizers running.
REQ-024 SHALL never wrap a counter: input 1 at CNT_MAX keeps CNT_MAX, and input 0 at 0 keeps 0.

Reset
REQ-025 SHALL, on any edge with resetN=1, clear synchronizers, counters, FSMs (to LOW), toggle registers and pulse registers to 0; reset SHALL override enable.
REQ-026 SHALL, in the cycle after a reset edge, drive out_filt=0, rise=0, fall=0 and any_change=0, even if reset was asserted mid-count or mid-pulse.

Verification (defaults, SYNC_EN=1)
REQ-027 SHALL verify: hold resetN=1 for 3 cycles with in=all-ones -> all outputs 0 throughout; after release, out_filt[0]=1 and rise[0]=1 for exactly one cycle 14 cycles later (2 synchronizer + 12 count).
REQ-028 SHALL verify: in[1]=1 for 11 cycles then 0 -> out_filt[1], rise[1] and any_change stay 0; the counter returns to 0.
REQ-029 SHALL verify: channel saturated at 15 and HIGH, then in=0 -> fall pulses once 12 counting edges later (counter = 3); a burst back to 1 while counter=8 produces no rise.
REQ-030 SHALL verify: mode_toggle[2]=1 with three clean presses -> out_filt[2] sequence 1,0,1; switching to mode_toggle[2]=0 immediately shows the level state.
REQ-031 SHALL verify: enable=0 for 20 cycles during a stable press -> counters frozen and no pulses; after enable=1, counting resumes from the frozen value.
REQ-032 SHALL verify: resetN=1 asserted in the same cycle as a rise pulse -> pulse and level cleared next cycle; simultaneous rise on channel 0 and fall on channel 3 -> a single any_change cycle.
